// File: rtl/ahb_waitstate_slave_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the wait-state responder.
//   HTRANS_* : transfer-type codes on HTRANS[1:0]
//   HRESP_*  : response codes on HRESP
//   state_t  : responder data-phase FSM state
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // NONSEQ or SEQ: the only transfer types that start a data phase.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_waitstate_slave_if.sv
// ahb_waitstate_slave_if: AHB-Lite bus bundle between one master/decoder
// side and one responder.
//   HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY : driven by the bus side
//   HREADYOUT, HRESP, HRDATA                    : driven by the responder
interface ahb_waitstate_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_waitstate_slave_mem.sv
// ahb_word_mem: DEPTH x 32 register-file word memory.
//   clk   : write clock
//   we    : write enable, commits wdata to waddr at the rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : asynchronous read data
// Contents are not reset.
module ahb_word_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_waitstate_slave.sv
// ahb_waitstate_slave: AHB-Lite word responder with WAIT_STATES wait cycles
// per OKAY transfer and a two-cycle ERROR for out-of-range/unaligned
// addresses.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus (slave)   : AHB-Lite signals; HREADYOUT/HRESP come from registers,
//                   HRDATA from the registered index and the memory
module ahb_waitstate_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_waitstate_slave_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  state_t        state;
  logic [3:0]    wcnt;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic          hreadyout_q;
  logic          hresp_q;

  logic [31:0]   offset;
  logic          addr_ok;
  logic          accept;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  // offset < SPAN together with HADDR >= BASE_ADDR is the inclusive range
  // test without forming BASE_ADDR + 4*DEPTH - 1.
  assign offset  = bus.HADDR - BASE_ADDR;
  assign addr_ok = (bus.HADDR >= BASE_ADDR) && (offset < SPAN) &&
                   (bus.HADDR[1:0] == 2'b00);
  assign accept  = bus.HSEL && bus.HREADY && is_active(bus.HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept) begin
            idx_q <= offset[AW+1:2];
            wr_q  <= bus.HWRITE;
            if (!addr_ok) begin
              state       <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WS != 4'd0) begin
              state       <= ST_WAIT;
              wcnt        <= WS;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
            end else begin
              state       <= ST_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state       <= ST_DATA;
            hreadyout_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // HWDATA is valid in the final data-phase cycle; commit on the edge that
  // ends it, which is also the edge starting any overlapping read.
  assign mem_we = (state == ST_DATA) && wr_q;

  ahb_word_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (bus.HWDATA),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = ((state == ST_WAIT || state == ST_DATA) && !wr_q) ?
                         mem_rdata : '0;

endmodule

// File: tb/tb_ahb_waitstate_slave.sv
module tb_ahb_waitstate_slave;
  import ahb_pkg::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rstn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  int          dsel;

  int tests = 0;
  int fails = 0;

  xfer_t seq_q[$];
  xfer_t exp_q[$];

  // Three instances: WAIT_STATES = 1, 3, 0. Only the selected one is out of
  // reset; the others are held in reset.
  ahb_waitstate_slave_if bus[3] ();
  logic        rdy_a   [3];
  logic        resp_a  [3];
  logic [31:0] rdata_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].HSEL   = hsel;
    assign bus[g].HADDR  = haddr;
    assign bus[g].HTRANS = htrans;
    assign bus[g].HWRITE = hwrite;
    assign bus[g].HWDATA = hwdata;
    assign bus[g].HREADY = bus[g].HREADYOUT;
    assign rdy_a[g]   = bus[g].HREADYOUT;
    assign resp_a[g]  = bus[g].HRESP;
    assign rdata_a[g] = bus[g].HRDATA;

    ahb_waitstate_slave #(
      .BASE_ADDR   (32'h1000_0000),
      .DEPTH       (64),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .HCLK    (clk),
      .HRESETn (rstn[g]),
      .bus     (bus[g])
    );
  end

  logic        m_rdy, m_resp, m_rstn;
  logic [31:0] m_rdata;
  assign m_rdy   = rdy_a[dsel];
  assign m_resp  = resp_a[dsel];
  assign m_rdata = rdata_a[dsel];
  assign m_rstn  = rstn[dsel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic xfer_t xw(input logic [31:0] a, input logic [31:0] d,
                               input logic r, input int w);
    xfer_t x;
    x.sel = 1'b1; x.trans = HTRANS_NONSEQ; x.wr = 1'b1; x.addr = a; x.wdata = d;
    x.exp_resp = r; x.exp_rdata = 32'h0; x.exp_waits = w;
    return x;
  endfunction

  function automatic xfer_t xr(input logic [31:0] a, input logic [31:0] d,
                               input logic r, input int w);
    xfer_t x;
    x.sel = 1'b1; x.trans = HTRANS_NONSEQ; x.wr = 1'b0; x.addr = a;
    x.wdata = 32'h5A5A_0000 ^ a;
    x.exp_resp = r; x.exp_rdata = d; x.exp_waits = w;
    return x;
  endfunction

  // A cycle that must not start a transfer.
  function automatic xfer_t xn(input logic s, input logic [1:0] t,
                               input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.sel = s; x.trans = t; x.wr = 1'b1; x.addr = a; x.wdata = d;
    x.exp_resp = 1'b0; x.exp_rdata = 32'h0; x.exp_waits = 0;
    return x;
  endfunction

  // Scoreboard monitor: tracks the data phase from bus-level accepts and
  // compares against the queued expectation when HREADYOUT rises.
  logic mon_active = 1'b0;
  int   mon_waits  = 0;
  logic mon_wbad   = 1'b0;
  xfer_t e;

  always @(negedge clk) begin
    if (!m_rstn) begin
      mon_active = 1'b0;
      mon_waits  = 0;
      mon_wbad   = 1'b0;
      exp_q.delete();
    end else begin
      if (mon_active) begin
        if (!m_rdy) begin
          mon_waits++;
          if (exp_q.size() != 0 && m_resp !== exp_q[0].exp_resp) mon_wbad = 1'b1;
        end else if (exp_q.size() == 0) begin
          check("orphan_data_phase", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("waits@%h", e.addr), 32'(mon_waits), 32'(e.exp_waits));
          check($sformatf("hresp@%h", e.addr), 32'(m_resp), 32'(e.exp_resp));
          check($sformatf("wait_hresp@%h", e.addr), 32'(mon_wbad), 32'd0);
          check($sformatf("hrdata@%h", e.addr), m_rdata, e.exp_rdata);
          mon_waits = 0;
          mon_wbad  = 1'b0;
        end
      end else begin
        check("idle_ready_resp", {30'd0, m_rdy, m_resp}, 32'h2);
        check("idle_hrdata", m_rdata, 32'h0);
      end
      if (m_rdy) mon_active = hsel && htrans[1];
    end
  end

  task automatic present(output xfer_t ap);
    xfer_t idle_x;
    idle_x = xn(1'b0, HTRANS_IDLE, 32'h0, 32'h0);
    if (seq_q.size() != 0) ap = seq_q.pop_front();
    else ap = idle_x;
    hsel = ap.sel; htrans = ap.trans; hwrite = ap.wr; haddr = ap.addr;
    if (ap.sel && ap.trans[1]) exp_q.push_back(ap);
  endtask

  // Pipelined master: address phase advances on each edge where HREADY was
  // high; HWDATA follows one accepted phase later.
  task automatic run_seq(input string tag, output int ncyc);
    xfer_t ap;
    logic  ap_real, rdy;
    ncyc = 0;
    present(ap);
    ap_real = ap.sel && ap.trans[1];
    while (1) begin
      @(negedge clk);
      rdy = m_rdy;
      @(posedge clk);
      #1;
      ncyc++;
      if (rdy) begin
        hwdata = ap.wdata;
        if (!ap_real && seq_q.size() == 0) break;
        present(ap);
        ap_real = ap.sel && ap.trans[1];
      end
      if (ncyc > 200) begin
        tests++; fails++;
        $display("FAIL timeout_%s: got %0d cycles, expected <= 200", tag, ncyc);
        seq_q.delete();
        break;
      end
    end
  endtask

  task automatic do_reset(input int k);
    rstn = '0; dsel = k;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0; hwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_resp", {30'd0, m_rdy, m_resp}, 32'h2);
    check("reset_hrdata", m_rdata, 32'h0);
    rstn[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int    n;
    xfer_t s;
    rstn = '0; dsel = 0;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0; hwdata = '0;

    // ---- WAIT_STATES = 1 ----
    do_reset(0);
    seq_q.push_back(xw(32'h1000_0000, 32'hAAAA_BBBB, 1'b0, 1));
    seq_q.push_back(xr(32'h1000_0000, 32'hAAAA_BBBB, 1'b0, 1));
    run_seq("wr_rd", n);

    seq_q.push_back(xw(32'h1000_0010, 32'h1111_1111, 1'b0, 1));
    seq_q.push_back(xw(32'h1000_0014, 32'h2222_2222, 1'b0, 1));
    seq_q.push_back(xw(32'h1000_0018, 32'h3333_3333, 1'b0, 1));
    seq_q.push_back(xr(32'h1000_0010, 32'h1111_1111, 1'b0, 1));
    s = xr(32'h1000_0014, 32'h2222_2222, 1'b0, 1);
    s.trans = HTRANS_SEQ;
    seq_q.push_back(s);
    seq_q.push_back(xr(32'h1000_0018, 32'h3333_3333, 1'b0, 1));
    run_seq("b2b", n);
    // n counts the accept edge of the first transfer plus its data phases.
    check("b2b_data_cycles", 32'(n - 1), 32'd12);

    // Last word, out-of-range and unaligned; the 1000_0100 and FFDF_FDFF
    // writes would alias words 0 and 63 if an errored write committed.
    seq_q.push_back(xw(32'h1000_00FC, 32'h6363_6363, 1'b0, 1));
    seq_q.push_back(xw(32'hFFDF_FDFF, 32'h1234_5678, 1'b1, 1));
    seq_q.push_back(xr(32'h1000_0002, 32'h0, 1'b1, 1));
    seq_q.push_back(xw(32'h1000_0100, 32'h8765_4321, 1'b1, 1));
    seq_q.push_back(xr(32'h0FFF_FFFC, 32'h0, 1'b1, 1));
    seq_q.push_back(xr(32'h1000_00FC, 32'h6363_6363, 1'b0, 1));
    run_seq("errors", n);

    seq_q.push_back(xn(1'b1, HTRANS_IDLE, 32'h1000_0000, 32'hFFFF_FFFF));
    seq_q.push_back(xr(32'h1000_0000, 32'hAAAA_BBBB, 1'b0, 1));
    seq_q.push_back(xw(32'h1000_0004, 32'h5555_5555, 1'b0, 1));
    seq_q.push_back(xr(32'h1000_0004, 32'h5555_5555, 1'b0, 1));
    seq_q.push_back(xn(1'b1, HTRANS_BUSY, 32'h1000_0004, 32'h0000_0001));
    seq_q.push_back(xn(1'b0, HTRANS_NONSEQ, 32'h1000_0004, 32'h0000_0002));
    seq_q.push_back(xr(32'h1000_0004, 32'h5555_5555, 1'b0, 1));
    run_seq("idle_overwrite", n);

    // ---- WAIT_STATES = 3 ----
    do_reset(1);
    seq_q.push_back(xw(32'h1000_0020, 32'h0BAD_CAFE, 1'b0, 3));
    run_seq("ws3_prefill", n);

    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h1000_0020;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
    check("mid_wait_ready", 32'(m_rdy), 32'd0);
    @(posedge clk);
    #1;
    rstn[1] = 1'b0;
    #1;
    check("rst_mid_wait_ready_resp", {30'd0, m_rdy, m_resp}, 32'h2);
    check("rst_mid_wait_hrdata", m_rdata, 32'h0);
    @(posedge clk);
    #1;
    rstn[1] = 1'b1;
    hwdata = '0;
    @(posedge clk);
    #1;
    seq_q.push_back(xr(32'h1000_0020, 32'h0BAD_CAFE, 1'b0, 3));
    seq_q.push_back(xr(32'h1000_0021, 32'h0, 1'b1, 1));
    run_seq("ws3_after_reset", n);

    // ---- WAIT_STATES = 0 ----
    do_reset(2);
    seq_q.push_back(xw(32'h1000_0008, 32'hCAFE_F00D, 1'b0, 0));
    seq_q.push_back(xw(32'h1000_000C, 32'h0F0F_0F0F, 1'b0, 0));
    seq_q.push_back(xr(32'h1000_0008, 32'hCAFE_F00D, 1'b0, 0));
    seq_q.push_back(xr(32'h0FFF_FFFC, 32'h0, 1'b1, 1));
    seq_q.push_back(xr(32'h1000_000C, 32'h0F0F_0F0F, 1'b0, 0));
    seq_q.push_back(xw(32'h1000_0010, 32'h7777_7777, 1'b0, 0));
    seq_q.push_back(xr(32'h1000_0010, 32'h7777_7777, 1'b0, 0));
    run_seq("ws0", n);
    check("ws0_cycles", 32'(n), 32'd9);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
